// File: rtl/obstacle_sequencer_if.sv
// Column-side bundle between the obstacle sequencer and its column instances.
interface obstacle_sequencer_if #(
    parameter int unsigned NUM_COLS = 3
);
    logic [NUM_COLS-1:0]    column_idle;
    logic [NUM_COLS-1:0]    will_collide;
    logic [NUM_COLS-1:0]    passed_through;
    logic [NUM_COLS-1:0]    start_moving;
    logic [NUM_COLS*10-1:0] safe_center;

    // Sequencer drives launches and gap centres, columns report status.
    modport master (
        input  column_idle,
        input  will_collide,
        input  passed_through,
        output start_moving,
        output safe_center
    );

    modport slave (
        output column_idle,
        output will_collide,
        output passed_through,
        input  start_moving,
        input  safe_center
    );
endinterface

// File: rtl/obstacle_sequencer.sv
// Game-level sequencer: launches obstacle columns, assigns pseudo-random safe
// gaps, tracks score / gravity flip and runs the IDLE/RUN/DEAD game state.
module obstacle_sequencer #(
    parameter int unsigned NUM_COLS  = 3,
    parameter int unsigned SPAWN_GAP = 40,
    parameter int unsigned SCORE_W   = 10,
    parameter logic [15:0] LFSR_SEED = 16'hACE1,
    parameter int unsigned SAFE_MIN  = 150,
    parameter int unsigned SAFE_MAX  = 330
) (
    input  logic                   frame_clk,
    input  logic                   Reset_n,
    input  logic                   start_btn,
    obstacle_sequencer_if.master   col,
    output logic [1:0]             game_state,
    output logic                   gravity_flip,
    output logic [SCORE_W-1:0]     score
);
    localparam int unsigned SC_W    = 10;
    localparam int unsigned PC_W    = 4;
    localparam int unsigned SUM_W   = SCORE_W + PC_W;
    localparam int unsigned GAP_W   = $clog2(SPAWN_GAP);
    localparam int unsigned RANGE   = SAFE_MAX - SAFE_MIN;
    localparam logic [GAP_W-1:0] GAP_MAX    = GAP_W'(SPAWN_GAP - 1);
    localparam logic [15:0]      LFSR_TAPS  = 16'hB400;
    localparam logic [15:0]      LFSR_INIT  = (LFSR_SEED == 16'h0000) ? 16'h0001 : LFSR_SEED;
    localparam logic [SC_W-1:0]  CENTRE_RST = SC_W'(240);

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_RUN  = 2'b01,
        S_DEAD = 2'b10
    } state_t;

    state_t                   r_state;
    logic [GAP_W-1:0]         r_gap_cnt;
    logic [15:0]              r_lfsr;
    logic                     r_btn_q;
    logic [NUM_COLS-1:0]      r_pt_q;
    logic [NUM_COLS-1:0]      r_start_moving;
    logic [NUM_COLS*SC_W-1:0] r_safe_center;
    logic [SCORE_W-1:0]       r_score;
    logic                     r_flip;

    logic                     w_btn_rise;
    logic [NUM_COLS-1:0]      w_pass_rise;
    logic [15:0]              w_lfsr_next;
    logic [7:0]               w_v;
    logic [SC_W-1:0]          w_centre;
    logic [PC_W-1:0]          w_pc;
    logic [SUM_W-1:0]         w_sum;
    logic [SCORE_W-1:0]       w_score_next;
    logic [NUM_COLS-1:0]      w_pick;
    logic                     w_spawn;

    assign w_btn_rise  = start_btn & ~r_btn_q;
    assign w_pass_rise = col.passed_through & ~r_pt_q;
    assign w_lfsr_next = {1'b0, r_lfsr[15:1]} ^ (r_lfsr[0] ? LFSR_TAPS : 16'h0000);

    // Lowest set bit of column_idle as a one-hot launch vector.
    assign w_pick  = col.column_idle & (~col.column_idle + NUM_COLS'(1));
    assign w_spawn = (r_gap_cnt == GAP_MAX) && (|col.column_idle);

    // Fold the low LFSR byte into [0, RANGE] and offset to the safe window.
    always_comb begin
        w_v = r_lfsr[7:0];
        if (w_v > 8'(RANGE)) begin
            w_v = w_v - 8'(RANGE + 1);
        end
        w_centre = SC_W'(SAFE_MIN) + SC_W'(w_v);
    end

    // Count newly passed columns and form the saturated next score.
    always_comb begin
        w_pc = '0;
        for (int unsigned i = 0; i < NUM_COLS; i++) begin
            w_pc = w_pc + PC_W'(w_pass_rise[i]);
        end
        w_sum        = SUM_W'(r_score) + SUM_W'(w_pc);
        w_score_next = (w_sum[SUM_W-1:SCORE_W] != '0) ? {SCORE_W{1'b1}} : w_sum[SCORE_W-1:0];
    end

    // Game state machine with registered launch, centre, score and flip outputs.
    always_ff @(posedge frame_clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_state        <= S_IDLE;
            r_gap_cnt      <= '0;
            r_lfsr         <= LFSR_INIT;
            r_btn_q        <= 1'b0;
            r_pt_q         <= '0;
            r_start_moving <= '0;
            r_safe_center  <= {NUM_COLS{CENTRE_RST}};
            r_score        <= '0;
            r_flip         <= 1'b0;
        end else begin
            r_btn_q        <= start_btn;
            r_pt_q         <= col.passed_through;
            r_lfsr         <= w_lfsr_next;
            r_start_moving <= '0;
            case (r_state)
                S_IDLE: begin
                    if (w_btn_rise) begin
                        r_state   <= S_RUN;
                        r_score   <= '0;
                        r_flip    <= 1'b0;
                        r_gap_cnt <= GAP_MAX;
                    end
                end
                S_RUN: begin
                    if (|col.will_collide) begin
                        r_state <= S_DEAD;
                    end else begin
                        r_score <= w_score_next;
                        r_flip  <= r_flip ^ w_pc[0];
                        if (w_spawn) begin
                            r_start_moving <= w_pick;
                            for (int unsigned i = 0; i < NUM_COLS; i++) begin
                                if (w_pick[i]) begin
                                    r_safe_center[i*SC_W +: SC_W] <= w_centre;
                                end
                            end
                            r_gap_cnt <= '0;
                        end else if (r_gap_cnt != GAP_MAX) begin
                            r_gap_cnt <= r_gap_cnt + GAP_W'(1);
                        end
                    end
                end
                S_DEAD: begin
                    if (w_btn_rise) begin
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign col.start_moving = r_start_moving;
    assign col.safe_center  = r_safe_center;
    assign game_state       = r_state;
    assign gravity_flip     = r_flip;
    assign score            = r_score;
endmodule

// File: tb/tb_obstacle_sequencer.sv
// Scoreboard bench for obstacle_sequencer: stimulus queues expected launches and
// status changes, monitors pop and compare whenever the DUTs present them.
module tb_obstacle_sequencer;
    localparam int unsigned NC = 3;

    typedef struct { int onehot; int frame; } spawn_t;
    typedef struct { int st; int sc; int fl; } stat_t;

    logic        frame_clk = 1'b0;
    logic        Reset_n;
    logic        a_btn, b_btn;
    logic [1:0]  a_state, b_state;
    logic        a_flip, b_flip;
    logic [9:0]  a_score;
    logic [1:0]  b_score;

    obstacle_sequencer_if #(.NUM_COLS(NC)) a_if();
    obstacle_sequencer_if #(.NUM_COLS(NC)) b_if();

    obstacle_sequencer #(.NUM_COLS(NC)) u_a (
        .frame_clk(frame_clk), .Reset_n(Reset_n), .start_btn(a_btn), .col(a_if),
        .game_state(a_state), .gravity_flip(a_flip), .score(a_score)
    );

    obstacle_sequencer #(.NUM_COLS(NC), .SPAWN_GAP(2), .SCORE_W(2)) u_b (
        .frame_clk(frame_clk), .Reset_n(Reset_n), .start_btn(b_btn), .col(b_if),
        .game_state(b_state), .gravity_flip(b_flip), .score(b_score)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    int exp_sc[NC];
    int b_spawns = 0;
    spawn_t a_sq[$], b_sq[$];
    stat_t  a_tq[$], b_tq[$];
    stat_t  a_prev, b_prev;
    logic [15:0] m_lfsr, m_prev;

    always #5 frame_clk = ~frame_clk;
    always @(posedge frame_clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (cyc %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic note_fail(input string msg);
        n_cmp++;
        n_bad++;
        $display("FAIL %s (cyc %0d)", msg, cyc);
    endtask

    task automatic tick();
        @(posedge frame_clk);
        #1;
    endtask

    task automatic wait_cyc(input int t);
        while (cyc < t) tick();
    endtask

    function automatic logic [15:0] galois(input logic [15:0] l);
        logic [15:0] n;
        n = l >> 1;
        if (l[0]) n = n ^ 16'hB400;
        return n;
    endfunction

    function automatic int centre(input logic [15:0] l);
        int v;
        v = int'(l[7:0]);
        if (v > 180) v = v - 181;
        return 150 + v;
    endfunction

    // Reference LFSR; m_prev is the value the DUT used at the latest edge.
    always @(posedge frame_clk or negedge Reset_n) begin
        if (!Reset_n) begin
            m_lfsr <= 16'hACE1;
            m_prev <= 16'h0000;
        end else begin
            m_prev <= m_lfsr;
            m_lfsr <= galois(m_lfsr);
        end
    end

    // Monitor for instance A: launches and status changes.
    always @(negedge frame_clk) begin
        stat_t cur;
        spawn_t e;
        stat_t t;
        if (a_if.start_moving != '0) begin
            if (a_sq.size() == 0) begin
                note_fail($sformatf("a_spawn unexpected start_moving=%b", a_if.start_moving));
            end else begin
                e = a_sq.pop_front();
                chk("a_spawn_onehot", 32'(a_if.start_moving), e.onehot);
                chk("a_spawn_frame", cyc, e.frame);
                for (int i = 0; i < NC; i++) if (a_if.start_moving[i]) exp_sc[i] = centre(m_prev);
                for (int i = 0; i < NC; i++) chk($sformatf("a_safe_center[%0d]", i), 32'(a_if.safe_center[i*10 +: 10]), exp_sc[i]);
            end
        end
        cur = '{int'(a_state), int'(a_score), int'(a_flip)};
        if (cur.st != a_prev.st || cur.sc != a_prev.sc || cur.fl != a_prev.fl) begin
            if (a_tq.size() == 0) begin
                note_fail($sformatf("a_status unexpected st=%0d score=%0d flip=%0d", cur.st, cur.sc, cur.fl));
            end else begin
                t = a_tq.pop_front();
                chk("a_game_state", cur.st, t.st);
                chk("a_score", cur.sc, t.sc);
                chk("a_gravity_flip", cur.fl, t.fl);
            end
            a_prev = cur;
        end
    end

    // Monitor for instance B: launches, centre range and status changes.
    always @(negedge frame_clk) begin
        stat_t cur;
        spawn_t e;
        stat_t t;
        int c;
        if (b_if.start_moving != '0) begin
            if (b_sq.size() == 0) begin
                note_fail($sformatf("b_spawn unexpected start_moving=%b", b_if.start_moving));
            end else begin
                e = b_sq.pop_front();
                b_spawns++;
                c = int'(b_if.safe_center[9:0]);
                chk("b_spawn_onehot", 32'(b_if.start_moving), e.onehot);
                chk("b_spawn_frame", cyc, e.frame);
                chk("b_safe_center", c, centre(m_prev));
                chk("b_centre_in_range", 32'(c >= 150 && c <= 330), 1);
            end
        end
        cur = '{int'(b_state), int'(b_score), int'(b_flip)};
        if (cur.st != b_prev.st || cur.sc != b_prev.sc || cur.fl != b_prev.fl) begin
            if (b_tq.size() == 0) begin
                note_fail($sformatf("b_status unexpected st=%0d score=%0d flip=%0d", cur.st, cur.sc, cur.fl));
            end else begin
                t = b_tq.pop_front();
                chk("b_game_state", cur.st, t.st);
                chk("b_score", cur.sc, t.sc);
                chk("b_gravity_flip", cur.fl, t.fl);
            end
            b_prev = cur;
        end
    end

    // Watchdog so the run always ends.
    initial begin
        #1_000_000;
        $display("FAIL watchdog expired");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
        $fatal(1, "watchdog");
    end

    task automatic check_reset_a(input string tag);
        chk({tag, "_state"}, 32'(a_state), 0);
        chk({tag, "_score"}, 32'(a_score), 0);
        chk({tag, "_flip"}, 32'(a_flip), 0);
        chk({tag, "_start_moving"}, 32'(a_if.start_moving), 0);
        for (int i = 0; i < NC; i++) chk($sformatf("%s_safe_center[%0d]", tag, i), 32'(a_if.safe_center[i*10 +: 10]), 240);
    endtask

    initial begin
        int k, m, r;
        int bsc, bfl;
        a_prev = '{0, 0, 0};
        b_prev = '{0, 0, 0};
        Reset_n = 1'b0;
        a_btn = 1'b0; b_btn = 1'b0;
        a_if.column_idle = '0; a_if.will_collide = '0; a_if.passed_through = '0;
        b_if.column_idle = '0; b_if.will_collide = '0; b_if.passed_through = '0;
        for (int i = 0; i < NC; i++) exp_sc[i] = 240;
        repeat (3) tick();
        check_reset_a("rst");
        Reset_n = 1'b1;
        tick(); tick();

        // Start a run with all columns idle: launches at +2 and 40 frames later.
        a_if.column_idle = 3'b111;
        a_btn = 1'b1;
        k = cyc;
        a_tq.push_back('{1, 0, 0});
        a_sq.push_back('{1, k + 2});
        a_sq.push_back('{2, k + 42});
        tick();
        a_btn = 1'b0;
        tick();
        a_if.column_idle = 3'b110;
        wait_cyc(k + 42);

        // Stall with no idle column, then release column 2; gap restarts after it.
        a_if.column_idle = 3'b000;
        repeat (100) tick();
        m = cyc;
        a_if.column_idle = 3'b100;
        a_sq.push_back('{4, m + 1});
        a_sq.push_back('{1, m + 41});
        tick();
        a_if.column_idle = 3'b001;
        wait_cyc(m + 41);
        a_if.column_idle = 3'b000;
        tick();

        // Two passes together, then a third; holding high adds nothing.
        a_tq.push_back('{1, 2, 0});
        a_if.passed_through = 3'b011;
        tick();
        a_tq.push_back('{1, 3, 1});
        a_if.passed_through = 3'b111;
        repeat (5) tick();
        a_if.passed_through = 3'b000;
        tick(); tick();

        // Collision with a simultaneous pass and an eligible spawn.
        a_tq.push_back('{2, 3, 1});
        a_if.will_collide = 3'b010;
        a_if.passed_through = 3'b001;
        a_if.column_idle = 3'b111;
        tick();
        a_if.will_collide = 3'b000;
        repeat (3) tick();

        // DEAD -> IDLE on one press held for several frames, then a new run.
        a_tq.push_back('{0, 3, 1});
        a_btn = 1'b1;
        repeat (3) tick();
        a_btn = 1'b0;
        tick();
        a_tq.push_back('{1, 0, 0});
        a_btn = 1'b1;
        tick();
        a_btn = 1'b0;
        tick();

        // Reset while a launch pulse is on the outputs.
        chk("pre_reset_start_moving", 32'(a_if.start_moving), 1);
        a_tq.push_back('{0, 0, 0});
        Reset_n = 1'b0;
        for (int i = 0; i < NC; i++) exp_sc[i] = 240;
        #1;
        check_reset_a("midrun_rst");
        a_if.column_idle = '0; a_if.passed_through = '0;
        tick(); tick();
        Reset_n = 1'b1;
        tick();

        // Narrow-score instance: saturation and a long stream of launches.
        b_if.column_idle = 3'b111;
        b_btn = 1'b1;
        r = cyc;
        b_tq.push_back('{1, 0, 0});
        for (int j = 0; j < 10000; j++) b_sq.push_back('{1, r + 2 + 2 * j});
        tick();
        b_btn = 1'b0;
        repeat (4) tick();
        bsc = 0; bfl = 0;
        for (int j = 0; j < 5; j++) begin
            bsc = (bsc < 3) ? bsc + 1 : 3;
            bfl = bfl ^ 1;
            b_tq.push_back('{1, bsc, bfl});
            b_if.passed_through = 3'b001;
            tick();
            b_if.passed_through = 3'b000;
            tick();
        end
        wait_cyc(r + 2 + 2 * 9999);
        b_if.column_idle = 3'b000;
        tick(); tick(); tick();

        chk("b_spawn_count", b_spawns, 10000);
        chk("a_spawn_queue_left", a_sq.size(), 0);
        chk("b_spawn_queue_left", b_sq.size(), 0);
        chk("a_status_queue_left", a_tq.size(), 0);
        chk("b_status_queue_left", b_tq.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
